ederah_stream_arbiter: RTL and testbench
========================================

EDERAH_STREAM_ARBITER -- requirements
Module: ederah_stream_arbiter

Interface
REQ-001 G_NUM_REQ, default 4: number of requesters sharing one EDERAH engine.
REQ-002 G_DATA_BUS_WIDTH, default 512: stream data width W.
REQ-003 G_JOB_FIFO_DEPTH, default 4 (power of 2): maximum number of jobs granted but whose results are not yet complete.
REQ-004 The block SHALL have one clock, data_clk; reset data_rst_n is asynchronous and active-low.
REQ-005 Ports SHALL be (name  direction  width  meaning):
- data_clk  in  1  clock.
- data_rst_n  in  1  async active-low reset.
- req_valid_i  in  N  job request, held until granted.
- req_hash_i  in  32*N  NFA hash of each requester's job.
- nfa_invalidate_i  in  1  pulse; forces a reload on the next grant.
- gnt_o  out  N  one-hot grant, held for the whole input job.
- gnt_reload_o  out  1  requester must send an NFA section before its query section.
- req_tdata_i  in  W*N  requester input data.
- req_tvalid_i  in  N  requester input valid.
- req_tlast_i  in  N  requester input last, marks the end of each section.
- req_tready_o  out  N  requester input ready.
- eng_rd_data_o  out  W  engine input data.
- eng_rd_valid_o  out  1  engine input valid.
- eng_rd_last_o  out  1  engine input last.
- eng_rd_stype_o  out  1  engine input section type: 0 = NFA, 1 = query.
- eng_rd_ready_i  in  1  engine input ready.
- eng_wr_data_i  in  W  engine result data.
- eng_wr_valid_i  in  1  engine result valid.
- eng_wr_last_i  in  1  engine result last.
- eng_wr_ready_o  out  1  engine result ready.
- rsp_tdata_o  out  W  result data, broadcast to all requesters.
- rsp_tvalid_o  out  N  per-requester result valid.
- rsp_tlast_o  out  1  result last.
- rsp_tready_i  in  N  per-requester result ready.
- done_o  out  N  one-cycle pulse when a job's last result beat is accepted.

Function
REQ-006 The input FSM SHALL have three states, IDLE, READ_NFA and READ_QUERY, with registered state.
REQ-007 IDLE, when any req_valid_i is set and the job FIFO is not full, SHALL register a round-robin winner into gnt_o. The search starts at last_grant+1 and wraps from N-1 to 0.
REQ-008 On that grant, gnt_reload_o SHALL be set when the loaded hash is invalid or differs from req_hash_i of the winner. The next state SHALL be READ_NFA if gnt_reload_o is set, else READ_QUERY.
REQ-009 On the grant, the winner's id SHALL be pushed into the job FIFO. If gnt_reload_o is set, the loaded hash SHALL be updated to the winner's hash and marked valid.
REQ-010 From READ_NFA the FSM SHALL go to READ_QUERY on a tlast handshake. From READ_QUERY it SHALL go to IDLE on a tlast handshake, clearing gnt_o and gnt_reload_o in the same transition.
REQ-011 In READ_NFA/READ_QUERY the granted requester's tdata, tvalid and tlast SHALL drive eng_rd_* combinationally. req_tready_o[g] SHALL equal eng_rd_ready_i, and all other req_tready_o bits SHALL be 0.
REQ-012 eng_rd_stype_o SHALL be 0 in READ_NFA and 1 otherwise. eng_rd_valid_o SHALL be 0 in IDLE.
REQ-013 Results SHALL be routed to the requester at the job FIFO head: rsp_tvalid_o[head] = eng_wr_valid_i, and eng_wr_ready_o = rsp_tready_i[head]. When the FIFO is empty, eng_wr_ready_o SHALL be 0 and rsp_tvalid_o SHALL be 0.
REQ-014 A result-side handshake with eng_wr_last_i SHALL pop the FIFO and pulse done_o[head] on the same cycle.
REQ-015 When a push and a pop occur in the same cycle, the FIFO count SHALL be unchanged. When the FIFO is full, no grant SHALL be issued.
REQ-016 nfa_invalidate_i SHALL clear the loaded-hash valid flag. If it coincides with a grant, the grant SHALL see the pre-invalidate value and the flag SHALL still end up invalid.
REQ-017 A requester dropping req_valid_i after being granted SHALL have no effect; the grant holds until the query tlast.

Reset
REQ-018 Asynchronous assertion of reset SHALL produce: state IDLE, gnt_o = 0, gnt_reload_o = 0, FIFO empty, last_grant = N-1, loaded hash = 0 with valid = 0, done_o = 0.
REQ-019 As a consequence of REQ-018, eng_rd_valid_o, eng_wr_ready_o and rsp_tvalid_o SHALL be 0 during reset.
REQ-020 Reset mid-job SHALL abandon the job, and the first job after reset SHALL get gnt_reload_o = 1.

Structure
REQ-021 A shared package ederah_arb_pkg SHALL hold the state enum (IDLE = 2'b00, READ_NFA = 2'b01, READ_QUERY = 2'b11) and the id width function clog2(N).
REQ-022 The job FIFO SHALL be a sub-module, ederah_id_fifo: register-based, with push/pop/full/empty.

Verification
REQ-023 Two jobs from requester 0 with hash 0xA5A5_0001: the first gets gnt_reload_o = 1 and stype 0 then 1; the second gets gnt_reload_o = 0 and stype 1 only.
REQ-024 All 4 requesters request continuously with the same hash: grants go 0,1,2,3,0. done_o pulses in grant order and rsp_tvalid_o is one-hot at the FIFO head.
REQ-025 Requester 2 uses hash 0x1 and requester 3 uses hash 0x2, alternating: every grant has gnt_reload_o = 1.
REQ-026 Engine results are stalled until 4 jobs are granted: no fifth grant occurs. On the first result tlast, done_o[first] pulses and the fifth grant follows.
REQ-027 Assert nfa_invalidate_i between two same-hash jobs: the second job gets gnt_reload_o = 1.
REQ-028 Assert reset during READ_NFA with eng_rd_ready_i = 1: outputs match REQ-018/REQ-019 immediately, and the next job gets gnt_reload_o = 1.

Source files
------------

// File: rtl/ederah_arb_pkg.sv
// Shared definitions for the EDERAH stream arbiter.
// Holds the input-side state encoding and the id/pointer width helpers.
package ederah_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        READ_NFA   = 2'b01,
        READ_QUERY = 2'b11
    } arb_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned id_width(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/ederah_id_fifo.sv
// Register-based FIFO of requester ids for jobs granted but not yet completed.
// Ports: clk/rst_n, push + push_id, pop, full, empty, head_id (oldest entry).
// Push when full and pop when empty are ignored.
module ederah_id_fifo
    import ederah_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head_id
);

    localparam int unsigned PTR_W = id_width(DEPTH);
    localparam int unsigned CNT_W = clog2(DEPTH + 1);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head_id = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage, pointers and occupancy; simultaneous push+pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ederah_stream_arbiter.sv
// Round-robin arbiter sharing one EDERAH engine between G_NUM_REQ requesters.
// Input side: grants one job at a time, forwarding an optional NFA section
// (when the engine's loaded NFA hash does not match) followed by the query
// section. Result side: routes engine results to the requester at the head
// of the outstanding-job FIFO and pulses done_o on its last accepted beat.
// Ports: data_clk/data_rst_n; req_* requester job/stream inputs; gnt_* grant;
// eng_rd_* engine input stream; eng_wr_* engine results; rsp_* result stream;
// done_o per-requester completion pulse.
module ederah_stream_arbiter
    import ederah_arb_pkg::*;
#(
    parameter int unsigned G_NUM_REQ        = 4,
    parameter int unsigned G_DATA_BUS_WIDTH = 512,
    parameter int unsigned G_JOB_FIFO_DEPTH = 4
) (
    input  logic                                  data_clk,
    input  logic                                  data_rst_n,
    input  logic [G_NUM_REQ-1:0]                  req_valid_i,
    input  logic [32*G_NUM_REQ-1:0]               req_hash_i,
    input  logic                                  nfa_invalidate_i,
    output logic [G_NUM_REQ-1:0]                  gnt_o,
    output logic                                  gnt_reload_o,
    input  logic [G_DATA_BUS_WIDTH*G_NUM_REQ-1:0] req_tdata_i,
    input  logic [G_NUM_REQ-1:0]                  req_tvalid_i,
    input  logic [G_NUM_REQ-1:0]                  req_tlast_i,
    output logic [G_NUM_REQ-1:0]                  req_tready_o,
    output logic [G_DATA_BUS_WIDTH-1:0]           eng_rd_data_o,
    output logic                                  eng_rd_valid_o,
    output logic                                  eng_rd_last_o,
    output logic                                  eng_rd_stype_o,
    input  logic                                  eng_rd_ready_i,
    input  logic [G_DATA_BUS_WIDTH-1:0]           eng_wr_data_i,
    input  logic                                  eng_wr_valid_i,
    input  logic                                  eng_wr_last_i,
    output logic                                  eng_wr_ready_o,
    output logic [G_DATA_BUS_WIDTH-1:0]           rsp_tdata_o,
    output logic [G_NUM_REQ-1:0]                  rsp_tvalid_o,
    output logic                                  rsp_tlast_o,
    input  logic [G_NUM_REQ-1:0]                  rsp_tready_i,
    output logic [G_NUM_REQ-1:0]                  done_o
);

    localparam int unsigned N    = G_NUM_REQ;
    localparam int unsigned W    = G_DATA_BUS_WIDTH;
    localparam int unsigned ID_W = id_width(N);

    arb_state_e      state;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] last_grant;
    logic [31:0]     loaded_hash;
    logic            hash_valid;

    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [31:0]     win_hash;
    logic            reload_c;
    logic            grant_c;
    logic            rd_last_hs;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [ID_W-1:0] head_id;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        logic [ID_W-1:0] idx;
        win_found = 1'b0;
        win_id    = last_grant;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = ID_W'((32'(last_grant) + i) % N);
            if (!win_found && req_valid_i[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign win_hash = req_hash_i[32'(win_id)*32 +: 32];
    assign reload_c = !hash_valid || (loaded_hash != win_hash);
    assign grant_c  = (state == IDLE) && win_found && !fifo_full;

    // Input-side FSM with registered grant outputs.
    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) begin
            state        <= IDLE;
            gnt_o        <= '0;
            gnt_reload_o <= 1'b0;
            gnt_id       <= '0;
            last_grant   <= ID_W'(N - 1);
            loaded_hash  <= '0;
            hash_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_c) begin
                        gnt_o        <= N'(1) << win_id;
                        gnt_reload_o <= reload_c;
                        gnt_id       <= win_id;
                        last_grant   <= win_id;
                        state        <= reload_c ? READ_NFA : READ_QUERY;
                        if (reload_c) begin
                            loaded_hash <= win_hash;
                            hash_valid  <= 1'b1;
                        end
                    end
                end
                READ_NFA: begin
                    if (rd_last_hs) begin
                        state <= READ_QUERY;
                    end
                end
                READ_QUERY: begin
                    if (rd_last_hs) begin
                        state        <= IDLE;
                        gnt_o        <= '0;
                        gnt_reload_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Invalidate wins over a same-cycle reload; the grant already used the old flag.
            if (nfa_invalidate_i) begin
                hash_valid <= 1'b0;
            end
        end
    end

    // Granted requester's stream onto the engine input.
    always_comb begin
        eng_rd_data_o  = req_tdata_i[32'(gnt_id)*W +: W];
        eng_rd_valid_o = 1'b0;
        eng_rd_last_o  = 1'b0;
        eng_rd_stype_o = (state != READ_NFA);
        req_tready_o   = '0;
        if (state != IDLE) begin
            eng_rd_valid_o       = req_tvalid_i[gnt_id];
            eng_rd_last_o        = req_tlast_i[gnt_id];
            req_tready_o[gnt_id] = eng_rd_ready_i;
        end
    end

    assign rd_last_hs = eng_rd_valid_o && eng_rd_ready_i && eng_rd_last_o;

    // Result routing to the oldest outstanding job.
    always_comb begin
        rsp_tvalid_o   = '0;
        done_o         = '0;
        eng_wr_ready_o = 1'b0;
        fifo_pop       = 1'b0;
        if (!fifo_empty) begin
            rsp_tvalid_o[head_id] = eng_wr_valid_i;
            eng_wr_ready_o        = rsp_tready_i[head_id];
            fifo_pop              = eng_wr_valid_i && rsp_tready_i[head_id] && eng_wr_last_i;
            done_o[head_id]       = fifo_pop;
        end
    end

    assign rsp_tdata_o = eng_wr_data_i;
    assign rsp_tlast_o = eng_wr_last_i;

    ederah_id_fifo #(
        .DEPTH (G_JOB_FIFO_DEPTH),
        .ID_W  (ID_W)
    ) u_id_fifo (
        .clk     (data_clk),
        .rst_n   (data_rst_n),
        .push    (grant_c),
        .push_id (win_id),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head_id (head_id)
    );

endmodule

// File: tb/tb_ederah_stream_arbiter.sv
// Self-checking bench for ederah_stream_arbiter: a job-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ederah_stream_arbiter;

    localparam int N = 4;
    localparam int W = 512;
    localparam int D = 4;

    logic             data_clk;
    logic             data_rst_n;
    logic [N-1:0]     req_valid_i;
    logic [32*N-1:0]  req_hash_i;
    logic             nfa_invalidate_i;
    logic [N-1:0]     gnt_o;
    logic             gnt_reload_o;
    logic [W*N-1:0]   req_tdata_i;
    logic [N-1:0]     req_tvalid_i;
    logic [N-1:0]     req_tlast_i;
    logic [N-1:0]     req_tready_o;
    logic [W-1:0]     eng_rd_data_o;
    logic             eng_rd_valid_o;
    logic             eng_rd_last_o;
    logic             eng_rd_stype_o;
    logic             eng_rd_ready_i;
    logic [W-1:0]     eng_wr_data_i;
    logic             eng_wr_valid_i;
    logic             eng_wr_last_i;
    logic             eng_wr_ready_o;
    logic [W-1:0]     rsp_tdata_o;
    logic [N-1:0]     rsp_tvalid_o;
    logic             rsp_tlast_o;
    logic [N-1:0]     rsp_tready_i;
    logic [N-1:0]     done_o;

    ederah_stream_arbiter #(
        .G_NUM_REQ        (N),
        .G_DATA_BUS_WIDTH (W),
        .G_JOB_FIFO_DEPTH (D)
    ) dut (
        .data_clk         (data_clk),
        .data_rst_n       (data_rst_n),
        .req_valid_i      (req_valid_i),
        .req_hash_i       (req_hash_i),
        .nfa_invalidate_i (nfa_invalidate_i),
        .gnt_o            (gnt_o),
        .gnt_reload_o     (gnt_reload_o),
        .req_tdata_i      (req_tdata_i),
        .req_tvalid_i     (req_tvalid_i),
        .req_tlast_i      (req_tlast_i),
        .req_tready_o     (req_tready_o),
        .eng_rd_data_o    (eng_rd_data_o),
        .eng_rd_valid_o   (eng_rd_valid_o),
        .eng_rd_last_o    (eng_rd_last_o),
        .eng_rd_stype_o   (eng_rd_stype_o),
        .eng_rd_ready_i   (eng_rd_ready_i),
        .eng_wr_data_i    (eng_wr_data_i),
        .eng_wr_valid_i   (eng_wr_valid_i),
        .eng_wr_last_i    (eng_wr_last_i),
        .eng_wr_ready_o   (eng_wr_ready_o),
        .rsp_tdata_o      (rsp_tdata_o),
        .rsp_tvalid_o     (rsp_tvalid_o),
        .rsp_tlast_o      (rsp_tlast_o),
        .rsp_tready_i     (rsp_tready_i),
        .done_o           (done_o)
    );

    initial data_clk = 1'b0;
    always #5 data_clk = ~data_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scenario knobs (written only by the scenario process)
    int  want [N];
    bit  stall;
    bit  rnd_en;

    // Driver state (written only by the driver process)
    int  granted [N];
    bit  beat_odd [N];
    int  eng_pend;
    bit  eng_beat;

    // Reference model: one job in flight on the input side, queue of outstanding owners.
    bit          m_busy   = 0;
    int          m_owner  = 0;
    bit          m_reload = 0;
    bit          m_sec    = 0;
    int          m_last   = N - 1;
    logic [31:0] m_hash   = '0;
    bit          m_hv     = 0;
    int          m_q [$];

    initial begin
        int  sz;
        bit  pop;
        int  w;
        bit  rel;
        forever begin
            @(posedge data_clk or negedge data_rst_n);
            if (!data_rst_n) begin
                m_busy = 0; m_owner = 0; m_reload = 0; m_sec = 0;
                m_last = N - 1; m_hash = '0; m_hv = 0; m_q.delete();
            end else begin
                sz  = m_q.size();
                pop = (sz > 0) && eng_wr_valid_i && rsp_tready_i[m_q[0]] && eng_wr_last_i;
                if (m_busy) begin
                    if (req_tvalid_i[m_owner] && eng_rd_ready_i && req_tlast_i[m_owner]) begin
                        if (!m_sec) m_sec = 1;
                        else        m_busy = 0;
                    end
                end else if (req_valid_i != '0 && sz < D) begin
                    w = 0;
                    for (int k = 1; k <= N; k++) begin
                        if (req_valid_i[(m_last + k) % N]) begin
                            w = (m_last + k) % N;
                            break;
                        end
                    end
                    rel = !m_hv || (m_hash != req_hash_i[w*32 +: 32]);
                    m_busy = 1; m_owner = w; m_reload = rel; m_sec = !rel; m_last = w;
                    if (rel) begin
                        m_hash = req_hash_i[w*32 +: 32];
                        m_hv   = 1;
                    end
                    m_q.push_back(w);
                end
                if (nfa_invalidate_i) m_hv = 0;
                if (pop) void'(m_q.pop_front());
            end
        end
    end

    // Logs of observed DUT events (written only by the compare process)
    int g_id [16];
    int g_rel [16];
    int g_cyc [16];
    int d_id [16];
    int d_cyc [16];
    int n_g, n_d, nfa_lasts, q_lasts, cyc;

    // Every-cycle comparison against the model, plus event logging.
    initial begin
        logic [N-1:0] e_gnt, e_rdy, e_rv, e_done;
        logic [N-1:0] prev_gnt;
        bit           hd;
        int           h;
        prev_gnt = '0; n_g = 0; n_d = 0; nfa_lasts = 0; q_lasts = 0; cyc = 0;
        forever begin
            @(negedge data_clk);
            cyc++;
            e_gnt = '0; e_rdy = '0; e_rv = '0; e_done = '0;
            if (m_busy) begin
                e_gnt[m_owner] = 1'b1;
                e_rdy[m_owner] = eng_rd_ready_i;
            end
            hd = (m_q.size() > 0);
            h  = hd ? m_q[0] : 0;
            if (hd && eng_wr_valid_i) e_rv[h] = 1'b1;
            if (hd && eng_wr_valid_i && rsp_tready_i[h] && eng_wr_last_i) e_done[h] = 1'b1;
            check("gnt_o", W'(gnt_o), W'(e_gnt));
            check("gnt_reload_o", W'(gnt_reload_o), W'(m_busy && m_reload));
            check("eng_rd_valid_o", W'(eng_rd_valid_o), W'(m_busy && req_tvalid_i[m_owner]));
            check("req_tready_o", W'(req_tready_o), W'(e_rdy));
            check("eng_rd_stype_o", W'(eng_rd_stype_o), W'(m_busy ? m_sec : 1'b1));
            if (m_busy) begin
                check("eng_rd_data_o", eng_rd_data_o, req_tdata_i[m_owner*W +: W]);
                check("eng_rd_last_o", W'(eng_rd_last_o), W'(req_tlast_i[m_owner]));
            end
            check("eng_wr_ready_o", W'(eng_wr_ready_o), W'(hd && rsp_tready_i[h]));
            check("rsp_tvalid_o", W'(rsp_tvalid_o), W'(e_rv));
            check("done_o", W'(done_o), W'(e_done));
            check("rsp_tdata_o", rsp_tdata_o, eng_wr_data_i);
            check("rsp_tlast_o", W'(rsp_tlast_o), W'(eng_wr_last_i));

            if (!data_rst_n) begin
                n_g = 0; n_d = 0; nfa_lasts = 0; q_lasts = 0; prev_gnt = '0;
            end else begin
                if (gnt_o != '0 && prev_gnt == '0 && n_g < 16) begin
                    for (int r = 0; r < N; r++) if (gnt_o[r]) g_id[n_g] = r;
                    g_rel[n_g] = int'(gnt_reload_o);
                    g_cyc[n_g] = cyc;
                    n_g++;
                end
                if (done_o != '0 && n_d < 16) begin
                    for (int r = 0; r < N; r++) if (done_o[r]) d_id[n_d] = r;
                    d_cyc[n_d] = cyc;
                    n_d++;
                end
                if (eng_rd_valid_o && eng_rd_ready_i && eng_rd_last_o) begin
                    if (eng_rd_stype_o) q_lasts++;
                    else                nfa_lasts++;
                end
                prev_gnt = gnt_o;
            end
        end
    end

    // Requester sources and engine result generator.
    initial begin
        bit           hs_rd [N];
        bit           q_done;
        bit           res_hs;
        logic [N-1:0] prev_g;
        prev_g = '0; eng_pend = 0; eng_beat = 0;
        for (int r = 0; r < N; r++) begin granted[r] = 0; beat_odd[r] = 0; hs_rd[r] = 0; end
        req_valid_i = '0; req_tvalid_i = '0; req_tlast_i = '0; req_tdata_i = '0;
        eng_rd_ready_i = 1'b0; eng_wr_valid_i = 1'b0; eng_wr_last_i = 1'b0;
        eng_wr_data_i = '0; rsp_tready_i = '0;
        forever begin
            @(negedge data_clk);
            for (int r = 0; r < N; r++) hs_rd[r] = req_tvalid_i[r] && req_tready_o[r];
            q_done = eng_rd_valid_o && eng_rd_ready_i && eng_rd_last_o && eng_rd_stype_o;
            res_hs = eng_wr_valid_i && eng_wr_ready_o;
            @(posedge data_clk);
            #1;
            if (!data_rst_n) begin
                for (int r = 0; r < N; r++) begin granted[r] = 0; beat_odd[r] = 0; end
                eng_pend = 0; eng_beat = 0; prev_g = '0;
            end else begin
                for (int r = 0; r < N; r++) begin
                    if (hs_rd[r]) beat_odd[r] = !beat_odd[r];
                    if (gnt_o[r] && !prev_g[r] && granted[r] < want[r]) granted[r]++;
                end
                if (q_done) eng_pend++;
                if (res_hs) begin
                    if (eng_beat) begin eng_beat = 0; eng_pend--; end
                    else          eng_beat = 1;
                end
                prev_g = gnt_o;
            end
            for (int r = 0; r < N; r++) begin
                req_valid_i[r]  = (want[r] > granted[r]);
                req_tvalid_i[r] = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                req_tlast_i[r]  = beat_odd[r];
                for (int j = 0; j < W / 32; j++) req_tdata_i[r*W + j*32 +: 32] = $urandom;
                rsp_tready_i[r] = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            eng_rd_ready_i = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            eng_wr_valid_i = (eng_pend > 0) && !stall && (rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1);
            eng_wr_last_i  = eng_beat;
            for (int j = 0; j < W / 32; j++) eng_wr_data_i[j*32 +: 32] = $urandom;
        end
    end

    task automatic do_reset();
        @(negedge data_clk);
        data_rst_n = 1'b0;
        for (int r = 0; r < N; r++) want[r] = 0;
        stall = 0;
        nfa_invalidate_i = 1'b0;
        repeat (3) @(negedge data_clk);
        data_rst_n = 1'b1;
    endtask

    task automatic set_hash_all(input logic [31:0] h);
        for (int r = 0; r < N; r++) req_hash_i[r*32 +: 32] = h;
    endtask

    task automatic wait_quiet(input int max_cyc, input string name);
        bit ok;
        bit all_granted;
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge data_clk);
            all_granted = 1;
            for (int r = 0; r < N; r++) if (granted[r] != want[r]) all_granted = 0;
            if (all_granted && gnt_o == '0 && eng_pend == 0 && !eng_beat && m_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check(name, W'(ok), W'(1));
    endtask

    initial begin
        bit seen;
        data_rst_n = 1'b0; nfa_invalidate_i = 1'b0; stall = 0; rnd_en = 0;
        req_hash_i = '0;
        for (int r = 0; r < N; r++) want[r] = 0;

        // Two jobs from requester 0 with the same hash
        do_reset();
        set_hash_all(32'hA5A5_0001);
        want[0] = 2;
        wait_quiet(400, "a_quiet");
        check("a_num_grants", W'(n_g), W'(2));
        check("a_grant0_id", W'(g_id[0]), W'(0));
        check("a_grant1_id", W'(g_id[1]), W'(0));
        check("a_grant0_reload", W'(g_rel[0]), W'(1));
        check("a_grant1_reload", W'(g_rel[1]), W'(0));
        check("a_nfa_lasts", W'(nfa_lasts), W'(1));
        check("a_query_lasts", W'(q_lasts), W'(2));

        // All requesters, same hash, round-robin order
        do_reset();
        rnd_en = 1;
        set_hash_all(32'h0000_1234);
        want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
        wait_quiet(2000, "b_quiet");
        check("b_num_grants", W'(n_g), W'(5));
        check("b_num_done", W'(n_d), W'(5));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("b_grant%0d_id", i), W'(g_id[i]), W'(i % 4));
            check($sformatf("b_grant%0d_reload", i), W'(g_rel[i]), W'(i == 0));
            check($sformatf("b_done%0d_id", i), W'(d_id[i]), W'(i % 4));
        end

        // Alternating hashes force a reload every grant
        do_reset();
        set_hash_all(32'h0);
        req_hash_i[2*32 +: 32] = 32'h1;
        req_hash_i[3*32 +: 32] = 32'h2;
        want[2] = 2; want[3] = 2;
        wait_quiet(2000, "c_quiet");
        check("c_num_grants", W'(n_g), W'(4));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("c_grant%0d_id", i), W'(g_id[i]), W'((i % 2 == 0) ? 2 : 3));
            check($sformatf("c_grant%0d_reload", i), W'(g_rel[i]), W'(1));
        end

        // Stalled results: FIFO fills at four jobs
        do_reset();
        set_hash_all(32'h0000_0077);
        stall = 1;
        for (int r = 0; r < N; r++) want[r] = 2;
        repeat (300) @(negedge data_clk);
        check("d_grants_while_full", W'(n_g), W'(4));
        check("d_done_while_stalled", W'(n_d), W'(0));
        for (int i = 0; i < 4; i++) check($sformatf("d_grant%0d_id", i), W'(g_id[i]), W'(i));
        stall = 0;
        wait_quiet(4000, "d_quiet");
        check("d_num_done", W'(n_d), W'(8));
        check("d_first_done_id", W'(d_id[0]), W'(0));
        check("d_fifth_grant_id", W'(g_id[4]), W'(0));
        check("d_fifth_after_done", W'(g_cyc[4] > d_cyc[0]), W'(1));

        // Invalidate between jobs, and coincident with a grant
        do_reset();
        rnd_en = 0;
        set_hash_all(32'h0000_0055);
        want[0] = 1;
        wait_quiet(400, "e_quiet1");
        nfa_invalidate_i = 1'b1;
        @(negedge data_clk);
        nfa_invalidate_i = 1'b0;
        want[0] = 2;
        wait_quiet(400, "e_quiet2");
        want[0] = 3;
        @(negedge data_clk);
        nfa_invalidate_i = 1'b1;
        @(negedge data_clk);
        nfa_invalidate_i = 1'b0;
        wait_quiet(400, "e_quiet3");
        want[0] = 4;
        wait_quiet(400, "e_quiet4");
        check("e_num_grants", W'(n_g), W'(4));
        check("e_grant0_reload", W'(g_rel[0]), W'(1));
        check("e_grant1_reload", W'(g_rel[1]), W'(1));
        check("e_grant2_reload", W'(g_rel[2]), W'(0));
        check("e_grant3_reload", W'(g_rel[3]), W'(1));

        // Reset during READ_NFA with the engine ready
        do_reset();
        rnd_en = 0;
        set_hash_all(32'h0000_0099);
        want[0] = 1;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge data_clk);
            if (gnt_o[0] && gnt_reload_o) begin
                seen = 1;
                break;
            end
        end
        check("f_reached_nfa", W'(seen), W'(1));
        #1;
        data_rst_n = 1'b0;
        want[0] = 0;
        #1;
        check("f_rst_gnt_o", W'(gnt_o), W'(0));
        check("f_rst_gnt_reload_o", W'(gnt_reload_o), W'(0));
        check("f_rst_eng_rd_valid_o", W'(eng_rd_valid_o), W'(0));
        check("f_rst_eng_wr_ready_o", W'(eng_wr_ready_o), W'(0));
        check("f_rst_rsp_tvalid_o", W'(rsp_tvalid_o), W'(0));
        check("f_rst_done_o", W'(done_o), W'(0));
        repeat (3) @(negedge data_clk);
        data_rst_n = 1'b1;
        want[0] = 1;
        wait_quiet(400, "f_quiet");
        check("f_num_grants", W'(n_g), W'(1));
        check("f_grant0_reload", W'(g_rel[0]), W'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
